mem_access_stage: RTL and testbench

// - MEM stage between the EXE/MEM and MEM/WB pipeline registers. Issues data-memory

---
 rtl/mem_access_stage_pkg.sv | 21 ++
 rtl/mem_access_stage_if.sv | 25 ++
 rtl/mem_access_stage_addr_xlate.sv | 24 ++
 rtl/mem_access_stage.sv | 151 +++++++++++++++
 tb/tb_mem_access_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Purpose: shared types and defaults for the MEM pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned TIMEOUT_DEF   = 255;

  // Wide enough to hold 0..TIMEOUT.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Purpose: request/ready bus between the MEM stage and the SRAM controller.
// Latency: n/a (wires only).
// Backpressure: master holds req/we/addr/wdata until a one-cycle mem_ready pulse.
// Ports: mem_req, mem_we, mem_addr, mem_wdata (master -> slave);
//        mem_ready, mem_rdata (slave -> master).
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage_addr_xlate.sv
// Purpose: byte address -> data-memory word address plus bad-address flag.
// Latency: combinational.
// Backpressure: none.
// Ports: byte_addr_i (effective byte address), word_addr_o (word index from
//        BASE_ADDR), bad_o (below BASE_ADDR or not word aligned).
module mem_addr_xlate
  import mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic [31:0]       byte_addr_i,
  output logic [ADDR_W-1:0] word_addr_o,
  output logic              bad_o
);

  localparam logic [31:0] BASE_VEC = BASE_ADDR;

  // BASE_ADDR is word aligned, so the low two bits never borrow and the word
  // index is just the difference of the word-address fields, already truncated.
  assign word_addr_o = byte_addr_i[ADDR_W+1:2] - BASE_VEC[ADDR_W+1:2];
  assign bad_o       = (byte_addr_i < BASE_VEC) || (byte_addr_i[1:0] != 2'b00);

endmodule

// File: rtl/mem_access_stage.sv
// Purpose: MEM stage; issues loads/stores to a multi-cycle SRAM and freezes the pipe.
// Latency: 1 cycle for non-memory ops (pass-through); memory ops freeze 1 + WAIT cycles, data in DONE.
// Backpressure: freeze holds all pipeline registers until the access completes or times out.
// Ports: clk/rst; EXE/MEM inputs (wb_en_in, mem_read_in, mem_write_in, dest_in,
//        alu_result_in, reg2_in); mem (SRAM bus, master side); freeze; MEM/WB
//        outputs (wb_en_out, mem_read_out, dest_out, alu_result_out, mem_data_out);
//        mem_err (high only in DONE after a bad address or timeout).
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_en_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [4:0]          dest_in,
  input  logic [31:0]         alu_result_in,
  input  logic [31:0]         reg2_in,
  mem_access_stage_if.master  mem,
  output logic                freeze,
  output logic                wb_en_out,
  output logic                mem_read_out,
  output logic [4:0]          dest_out,
  output logic [31:0]         alu_result_out,
  output logic [31:0]         mem_data_out,
  output logic                mem_err
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic              access;
  logic              addr_bad;
  logic [ADDR_W-1:0] word_addr;

  assign access = mem_read_in | mem_write_in;

  mem_addr_xlate #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) u_xlate (
    .byte_addr_i (alu_result_in),
    .word_addr_o (word_addr),
    .bad_o       (addr_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    freeze  = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          freeze = 1'b1;
          if (addr_bad) begin
            // No request goes out, so a bad store never reaches memory.
            state_d = DONE;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = WAIT;
            req_d   = 1'b1;
            we_d    = mem_write_in;  // read+write together counts as a write
            addr_d  = word_addr;
            wdata_d = reg2_in;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        freeze = 1'b1;
        if (mem.mem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b0;
          if (!we_q) data_d = mem.mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      DONE: begin
        // freeze low here lets EXE/MEM advance at the end of this cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign mem_err        = (state_q == DONE) && err_q;
  assign mem_data_out   = data_q;
  assign wb_en_out      = wb_en_in;
  assign mem_read_out   = mem_read_in;
  assign dest_out       = dest_in;
  assign alu_result_out = alu_result_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose: randomized self-checking bench for mem_access_stage against a transaction-level model.
// Latency: n/a.
// Backpressure: bench holds EXE/MEM inputs while an access is in flight.
module tb_mem_access_stage;

  localparam int unsigned BASE    = 1024;
  localparam int unsigned AW      = 16;
  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        wb_en_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [4:0]  dest_in;
  logic [31:0] alu_result_in;
  logic [31:0] reg2_in;
  logic        freeze;
  logic        wb_en_out;
  logic        mem_read_out;
  logic [4:0]  dest_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data_out;
  logic        mem_err;

  mem_access_stage_if #(.ADDR_W(AW)) bus ();

  mem_access_stage #(
    .BASE_ADDR (BASE),
    .ADDR_W    (AW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en_in       (wb_en_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .dest_in        (dest_in),
    .alu_result_in  (alu_result_in),
    .reg2_in        (reg2_in),
    .mem            (bus),
    .freeze         (freeze),
    .wb_en_out      (wb_en_out),
    .mem_read_out   (mem_read_out),
    .dest_out       (dest_out),
    .alu_result_out (alu_result_out),
    .mem_data_out   (mem_data_out),
    .mem_err        (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference SRAM contents (word-indexed) and the expected MEM/WB load register.
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One instruction through the stage. Called just after a rising edge with the
  // stage in IDLE; returns just after the rising edge that leaves DONE.
  // lat = WAIT cycle (1-based) in which the controller pulses ready; lat > TIMEOUT
  // means the controller never answers.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int lat);
    logic        acc, bad, tmo, wb;
    logic [4:0]  dst;
    logic [15:0] waddr;
    int          idx, waits_exp, nfreeze;

    wb  = 1'($urandom);
    dst = 5'($urandom);
    wb_en_in      = wb;
    dest_in       = dst;
    mem_read_in   = rd;
    mem_write_in  = wr;
    alu_result_in = a;
    reg2_in       = wd;

    acc   = rd | wr;
    bad   = (a < BASE) || (a[1:0] != 2'b00);
    waddr = 16'((a - BASE) >> 2);
    idx   = int'(waddr[5:0]);
    tmo   = acc && !bad && (lat > int'(TIMEOUT));
    waits_exp = (!acc || bad) ? 0 : (tmo ? int'(TIMEOUT) : lat);

    @(negedge clk);
    check("pass_alu", alu_result_out, a);
    check("pass_dest", 32'(dest_out), 32'(dst));
    check("pass_wb", 32'(wb_en_out), 32'(wb));
    check("pass_rd", 32'(mem_read_out), 32'(rd));
    check("idle_req", 32'(bus.mem_req), 32'd0);
    check("idle_err", 32'(mem_err), 32'd0);
    check("idle_data", mem_data_out, exp_data);
    if (!acc) begin
      check("nomem_freeze", 32'(freeze), 32'd0);
      @(posedge clk); #1;
      return;
    end
    nfreeze = freeze ? 1 : 0;

    for (int k = 1; k <= waits_exp; k++) begin
      @(posedge clk); #1;
      bus.mem_ready = (k == lat);
      bus.mem_rdata = (k == lat && !wr) ? ref_mem[idx] : $urandom;
      if (k == lat && wr) ref_mem[idx] = wd;
      @(negedge clk);
      if (freeze) nfreeze++;
      check("wait_req", 32'(bus.mem_req), 32'd1);
      check("wait_addr", 32'(bus.mem_addr), 32'(waddr));
      check("wait_we", 32'(bus.mem_we), 32'(wr));
      check("wait_wdata", bus.mem_wdata, wd);
    end

    // DONE cycle: a stray ready pulse here must be ignored.
    @(posedge clk); #1;
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = $urandom;
    if (bad || tmo) exp_data = 32'd0;
    else if (!wr)   exp_data = ref_mem[idx];
    @(negedge clk);
    check("done_freeze", 32'(freeze), 32'd0);
    check("done_req", 32'(bus.mem_req), 32'd0);
    check("done_err", 32'(mem_err), 32'(bad || tmo));
    check("done_data", mem_data_out, exp_data);
    check("freeze_len", 32'(nfreeze), 32'(1 + waits_exp));
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic        rd, wr;
    int          kind, lat;

    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    exp_data = 32'd0;

    rst = 1'b1;
    wb_en_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    dest_in = '0; alu_result_in = '0; reg2_in = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_data", mem_data_out, 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory op: pure pass-through, never freezes.
    repeat (3) run_op(1'b0, 1'b0, 32'h55, 32'h0, 1);

    // Load at 1028, ready in 3rd WAIT cycle.
    ref_mem[1] = 32'hDEADBEEF;
    run_op(1'b1, 1'b0, 32'd1028, $urandom, 3);

    // Reset in the 2nd WAIT cycle of a load; a late ready afterwards is ignored.
    mem_read_in = 1'b1; mem_write_in = 1'b0;
    alu_result_in = BASE + 32'd20; reg2_in = $urandom;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("prerst_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mem_read_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    exp_data = 32'd0;
    @(negedge clk);
    check("midrst_req", 32'(bus.mem_req), 32'd0);
    check("midrst_freeze", 32'(freeze), 32'd0);
    check("midrst_data", mem_data_out, 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("late_rdy_req", 32'(bus.mem_req), 32'd0);
    check("late_rdy_data", mem_data_out, 32'd0);
    check("late_rdy_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;

    // Store at 1032, ready after one WAIT cycle.
    run_op(1'b0, 1'b1, 32'd1032, 32'h12345678, 1);
    check("store_mem", ref_mem[2], 32'h12345678);
    // Read it back.
    run_op(1'b1, 1'b0, 32'd1032, $urandom, 2);
    // Misaligned and below-base loads.
    run_op(1'b1, 1'b0, 32'd1030, $urandom, 1);
    run_op(1'b1, 1'b0, 32'd512, $urandom, 1);
    // Controller never answers.
    run_op(1'b1, 1'b0, BASE + 32'd8, $urandom, TIMEOUT + 1);
    run_op(1'b0, 1'b1, BASE + 32'd12, $urandom, TIMEOUT + 1);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1, 2: a = BASE + 4 * $urandom_range(0, 63);
        3:       a = BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
        4:       a = $urandom_range(0, BASE - 1);
        default: a = $urandom;
      endcase
      rd  = 1'($urandom);
      wr  = 1'($urandom);
      lat = $urandom_range(1, TIMEOUT + 1);
      if (kind == 5) begin
        // Non-memory ALU op with an arbitrary result.
        rd = 1'b0; wr = 1'b0;
      end
      run_op(rd, wr, a, $urandom, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
